polynomial_evaluator: RTL and testbench

Parametrised successor to the fixed second-degree evaluator. It computes p(x) = sum of coef[i]·x^i for any DEGREE using Horner's method, one multiply-add per clock. The control FSM is built in, so the lx/m0/m1/m2/h/ls/lh strobes are no longer driven from switches. It sits between the operand sources (switches or parameters) and the 7-segment printer, which consumes result.

---
 rtl/poly_pkg.sv | 29 ++
 rtl/poly_mac_step.sv | 33 +++
 rtl/polynomial_evaluator.sv | 120 ++++++++++++
 tb/tb_polynomial_evaluator.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared types and helpers for the polynomial evaluator
// Contents:
//   MAX_DEGREE : largest supported polynomial degree
//   state_t    : evaluator FSM states (IDLE, MAC, DONE)
//   clog2      : index register width for a given coefficient count (min 1)
package poly_pkg;

    localparam int MAX_DEGREE = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 of n, clamped to at least 1 so a DEGREE=0 build still
    // gets a legal (one-bit) index register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i <= 16; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/poly_mac_step.sv
// rtl/poly_mac_step.sv - one combinational Horner step: acc*x + coef
// Build option: POLY_SATURATE_EN clamps the result to all ones on overflow.
// Ports:
//   acc      in  WIDTH  running accumulator
//   x        in  XW     polynomial variable
//   coef     in  WIDTH  coefficient for this step
//   next     out WIDTH  new accumulator (wrapped or saturated)
//   overflow out 1      full-precision value did not fit in WIDTH bits
module poly_mac_step #(
    parameter int WIDTH = 16,
    parameter int XW    = 4
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [XW-1:0]    x,
    input  logic [WIDTH-1:0] coef,
    output logic [WIDTH-1:0] next,
    output logic             overflow
);

    logic [WIDTH+XW-1:0] product;
    logic [WIDTH+XW:0]   sum;

    assign product  = {{XW{1'b0}}, acc} * {{WIDTH{1'b0}}, x};
    assign sum      = {1'b0, product} + {{(XW+1){1'b0}}, coef};
    assign overflow = |sum[WIDTH+XW:WIDTH];

`ifdef POLY_SATURATE_EN
    assign next = overflow ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign next = sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/polynomial_evaluator.sv
// rtl/polynomial_evaluator.sv - Horner polynomial evaluator, one MAC per clock
// Build option: POLY_SATURATE_EN (saturating MAC steps instead of wrapping).
// Ports:
//   clock    in  1                 system clock, rising edge
//   reset    in  1                 synchronous active-high reset
//   start    in  1                 request evaluation, honoured only in IDLE
//   x        in  XW                variable, latched on accepted start
//   coef     in  (DEGREE+1)*WIDTH  coef[i] at bits [i*WIDTH +: WIDTH]
//   busy     out 1                 evaluation in progress (MAC state)
//   done     out 1                 one-cycle pulse, result/overflow updated
//   result   out WIDTH             last completed p(x)
//   overflow out 1                some step of the last evaluation overflowed
module polynomial_evaluator #(
    parameter int WIDTH  = 16,
    parameter int XW     = 4,
    parameter int DEGREE = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [XW-1:0]             x,
    input  logic [(DEGREE+1)*WIDTH-1:0] coef,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          result,
    output logic                      overflow
);
    import poly_pkg::*;

    localparam int IW    = clog2(DEGREE + 1);
    localparam int NSLOT = 1 << IW;
    localparam logic [IW-1:0] IDX_INIT = (DEGREE == 0) ? IW'(0) : IW'(DEGREE - 1);

    state_t                     state;
    logic [XW-1:0]              x_q;
    logic [(DEGREE+1)*WIDTH-1:0] coef_q;
    logic [WIDTH-1:0]           acc;
    logic [IW-1:0]              idx;
    logic                       ovf;

    logic [WIDTH-1:0]           coef_arr [NSLOT];
    logic [WIDTH-1:0]           mac_next;
    logic                       mac_ovf;

    // Pad the coefficient table to a power of two so idx can index it
    // directly; unused slots read as zero and are never selected.
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g <= DEGREE) begin : g_used
            assign coef_arr[g] = coef_q[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign coef_arr[g] = '0;
        end
    end

    poly_mac_step #(
        .WIDTH (WIDTH),
        .XW    (XW)
    ) u_mac_step (
        .acc      (acc),
        .x        (x_q),
        .coef     (coef_arr[idx]),
        .next     (mac_next),
        .overflow (mac_ovf)
    );

    assign busy = (state == MAC);
    assign done = (state == DONE);

    // result/overflow are written on the edge entering DONE so that they
    // are already valid while done is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            x_q      <= '0;
            coef_q   <= '0;
            acc      <= '0;
            idx      <= '0;
            ovf      <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q    <= x;
                        coef_q <= coef;
                        acc    <= coef[DEGREE*WIDTH +: WIDTH];
                        idx    <= IDX_INIT;
                        ovf    <= 1'b0;
                        if (DEGREE == 0) begin
                            state    <= DONE;
                            result   <= coef[WIDTH-1:0];
                            overflow <= 1'b0;
                        end else begin
                            state <= MAC;
                        end
                    end
                end
                MAC: begin
                    acc <= mac_next;
                    ovf <= ovf | mac_ovf;
                    if (idx == '0) begin
                        state    <= DONE;
                        result   <= mac_next;
                        overflow <= ovf | mac_ovf;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polynomial_evaluator.sv
// tb/tb_polynomial_evaluator.sv - scoreboard bench for polynomial_evaluator (DEGREE 2, 0, 3)
module tb_polynomial_evaluator;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, start_d0, start_d3;
    logic [3:0]  x, x_d0, x_d3;
    logic [47:0] coef;
    logic [15:0] coef_d0;
    logic [63:0] coef_d3;
    logic        busy, done, overflow;
    logic        busy_d0, done_d0, overflow_d0;
    logic        busy_d3, done_d3, overflow_d3;
    logic [15:0] result, result_d0, result_d3;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    polynomial_evaluator #(.WIDTH(16), .XW(4), .DEGREE(2)) dut (
        .clock(clock), .reset(reset), .start(start), .x(x), .coef(coef),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    polynomial_evaluator #(.WIDTH(16), .XW(4), .DEGREE(0)) dut_d0 (
        .clock(clock), .reset(reset), .start(start_d0), .x(x_d0), .coef(coef_d0),
        .busy(busy_d0), .done(done_d0), .result(result_d0), .overflow(overflow_d0)
    );

    polynomial_evaluator #(.WIDTH(16), .XW(4), .DEGREE(3)) dut_d3 (
        .clock(clock), .reset(reset), .start(start_d3), .x(x_d3), .coef(coef_d3),
        .busy(busy_d3), .done(done_d3), .result(result_d3), .overflow(overflow_d3)
    );

    // Reference Horner evaluation at full precision.
    function automatic exp_t model(input int deg, input logic [3:0] xv, input logic [63:0] cf);
        exp_t        e;
        logic [20:0] full;
        logic [15:0] acc;
        acc   = cf[deg*16 +: 16];
        e.ovf = 1'b0;
        for (int i = deg - 1; i >= 0; i--) begin
            full = 21'(acc) * 21'(xv) + 21'(cf[i*16 +: 16]);
            if (full > 21'h00FFFF) begin
                e.ovf = 1'b1;
`ifdef POLY_SATURATE_EN
                acc = 16'hFFFF;
`else
                acc = full[15:0];
`endif
            end else begin
                acc = full[15:0];
            end
        end
        e.res = acc;
        return e;
    endfunction

    task automatic kick(input logic [3:0] xv, input logic [47:0] cv, input bit push);
        @(negedge clock);
        start = 1'b1;
        x     = xv;
        coef  = cv;
        if (push) sb.push_back(model(2, xv, {16'h0, cv}));
    endtask

    // Waits for done on the DEGREE=2 instance; cycles=0 means timeout.
    task automatic wait_done(input int max_cycles, input bit scramble, input bit restart,
                             output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (scramble && k == 1) begin
                x    = 4'($urandom);
                coef = 48'({$urandom, $urandom});
            end
            if (restart && k == 1) begin
                start = 1'b1;
                x     = 4'd2;
            end
            if (busy) busy_cycles++;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if ({busy, done, overflow} !== 3'b000 || result !== 16'h0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b ovf=%b result=%h, expected 0 0 0 0000",
                     busy, done, overflow, result);
        end
        reset = 1'b0;
    endtask

    task automatic test_baseline();
        int cyc, bc;
        exp_t e;
        kick(4'd1, {16'd1, 16'd1, 16'd1}, 1'b1);
        wait_done(10, 1'b0, 1'b0, cyc, bc);
        tests++;
        if (cyc != 3) begin fails++; $display("FAIL baseline_latency: got %0d expected 3", cyc); end
        tests++;
        if (bc != 2) begin fails++; $display("FAIL baseline_busy: got %0d expected 2", bc); end
        if (cyc != 0) begin
            e = sb.pop_front();
            tests++;
            if (result !== e.res || result !== 16'd3 || overflow !== 1'b0) begin
                fails++;
                $display("FAIL baseline_result: got %h/%b expected 0003/0", result, overflow);
            end
        end
    endtask

    task automatic test_general();
        int cyc, bc;
        exp_t e;
        logic [15:0] want [3] = '{16'h0028, 16'h0007, 16'h0028};
        for (int t = 0; t < 3; t++) begin
            kick((t == 1) ? 4'd0 : 4'd3, {16'd2, 16'd5, 16'd7}, 1'b1);
            wait_done(10, (t == 2), 1'b0, cyc, bc);
            tests++;
            if (cyc == 0) begin
                fails++;
                $display("FAIL general_%0d: timeout waiting for done", t);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || result !== want[t] || overflow !== e.ovf) begin
                    fails++;
                    $display("FAIL general_%0d: got %h/%b expected %h/%b", t, result, overflow, want[t], e.ovf);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int cyc, bc;
        exp_t e;
        logic [15:0] want;
`ifdef POLY_SATURATE_EN
        want = 16'hFFFF;
`else
        want = 16'h1000;
`endif
        kick(4'd15, {16'h1000, 16'h0, 16'h0}, 1'b1);
        wait_done(10, 1'b0, 1'b0, cyc, bc);
        tests++;
        if (cyc == 0) begin
            fails++;
            $display("FAIL overflow: timeout waiting for done");
        end else begin
            e = sb.pop_front();
            if (result !== e.res || result !== want || overflow !== 1'b1) begin
                fails++;
                $display("FAIL overflow: got %h/%b expected %h/1", result, overflow, want);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, bc, extra;
        exp_t e;
        kick(4'd1, {16'd1, 16'd1, 16'd1}, 1'b1);
        wait_done(10, 1'b0, 1'b1, cyc, bc);
        tests++;
        if (cyc != 3) begin fails++; $display("FAIL busy_start_latency: got %0d expected 3", cyc); end
        if (cyc != 0) begin
            e = sb.pop_front();
            tests++;
            if (result !== e.res || result !== 16'd3) begin
                fails++;
                $display("FAIL busy_start_result: got %h expected 0003", result);
            end
        end
        extra = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL busy_start_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        exp_t e;
        kick(4'd3, {16'd2, 16'd5, 16'd7}, 1'b1);
        wait_done(10, 1'b0, 1'b0, cyc, bc);
        if (cyc != 0) e = sb.pop_front();
        kick(4'd2, {16'd0, 16'd1, 16'd1}, 1'b1);
        wait_done(10, 1'b0, 1'b0, cyc, bc);
        tests++;
        if (cyc != 3) begin fails++; $display("FAIL back_to_back_latency: got %0d expected 3", cyc); end
        if (cyc != 0) begin
            e = sb.pop_front();
            tests++;
            if (result !== e.res || result !== 16'd3) begin
                fails++;
                $display("FAIL back_to_back_result: got %h expected 0003", result);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int extra;
        kick(4'd3, {16'd2, 16'd5, 16'd7}, 1'b0);
        @(negedge clock);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL reset_mid_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if ({busy, done, overflow} !== 3'b000 || result !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b ovf=%b result=%h, expected 0 0 0 0000",
                     busy, done, overflow, result);
        end
        reset = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL reset_mid_done: got %0d expected 0", extra); end
    endtask

    task automatic test_degree0();
        int cyc;
        exp_t e;
        @(negedge clock);
        start_d0 = 1'b1;
        x_d0     = 4'd9;
        coef_d0  = 16'h1234;
        sb.push_back(model(0, 4'd9, {48'h0, 16'h1234}));
        cyc = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            start_d0 = 1'b0;
            if (done_d0) begin cyc = k; break; end
        end
        tests++;
        if (cyc != 1) begin fails++; $display("FAIL degree0_latency: got %0d expected 1", cyc); end
        if (cyc != 0) begin
            e = sb.pop_front();
            tests++;
            if (result_d0 !== e.res || result_d0 !== 16'h1234 || overflow_d0 !== 1'b0) begin
                fails++;
                $display("FAIL degree0_result: got %h/%b expected 1234/0", result_d0, overflow_d0);
            end
        end
    endtask

    task automatic test_degree3();
        int cyc;
        exp_t e;
        @(negedge clock);
        start_d3 = 1'b1;
        x_d3     = 4'd2;
        coef_d3  = {16'd1, 16'd0, 16'd0, 16'd0};
        sb.push_back(model(3, 4'd2, {16'd1, 16'd0, 16'd0, 16'd0}));
        cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            start_d3 = 1'b0;
            if (done_d3) begin cyc = k; break; end
        end
        tests++;
        if (cyc != 4) begin fails++; $display("FAIL degree3_latency: got %0d expected 4", cyc); end
        if (cyc != 0) begin
            e = sb.pop_front();
            tests++;
            if (result_d3 !== e.res || result_d3 !== 16'd8 || overflow_d3 !== 1'b0) begin
                fails++;
                $display("FAIL degree3_result: got %h/%b expected 0008/0", result_d3, overflow_d3);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        start_d0 = 1'b0;
        start_d3 = 1'b0;
        x        = '0;
        x_d0     = '0;
        x_d3     = '0;
        coef     = '0;
        coef_d0  = '0;
        coef_d3  = '0;
        test_reset();
        test_baseline();
        test_general();
        test_overflow();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_degree0();
        test_degree3();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
